decision_tree_param: RTL

//  Parametrised successor to the fixed 3-input decision tree evaluator. Runs one

---
 rtl/decision_tree_param.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/decision_tree_param.sv
// rtl/decision_tree_param.sv - run-time loadable binary decision tree evaluator, one comparison per clock
module decision_tree_param #(
   parameter int DATA_W     = 8,
   parameter int N_FEAT     = 3,
   parameter int DEPTH      = 3,
   parameter int CMP_SIGNED = 0,
   localparam int FIDX_W    = (N_FEAT > 1) ? $clog2(N_FEAT) : 1
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       start_i,
   input  logic [N_FEAT*DATA_W-1:0]   x_i,
   input  logic                       cfg_we_i,
   input  logic                       cfg_sel_i,
   input  logic [DEPTH-1:0]           cfg_addr_i,
   input  logic [FIDX_W+DATA_W-1:0]   cfg_data_i,
   output logic [DATA_W-1:0]          y_o,
   output logic                       y_valid_o,
   output logic                       busy_o,
   output logic                       cfg_err_o
);

   localparam int N_NODE = (1 << DEPTH) - 1;
   localparam int N_LEAF = 1 << DEPTH;
   localparam int NODE_W = DEPTH + 1;
   localparam int LVL_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {S_IDLE, S_EVAL} state_t;

   state_t                     state_q, state_d;
   logic [N_FEAT*DATA_W-1:0]   x_q, x_d;
   logic [DEPTH-1:0]           node_q, node_d;
   logic [LVL_W-1:0]           lvl_q, lvl_d;
   logic [DATA_W-1:0]          y_q, y_d;
   logic                       y_valid_q, y_valid_d;
   logic                       cfg_err_q, cfg_err_d;

   logic [DATA_W-1:0]          node_thr_q  [N_NODE];
   logic [FIDX_W-1:0]          node_fidx_q [N_NODE];
   logic [DATA_W-1:0]          leaf_q      [N_LEAF];

   logic                       node_we, leaf_we;
   logic [DATA_W-1:0]          cur_thr, feat;
   logic [FIDX_W-1:0]          cur_fidx;
   logic                       go_left;
   logic [NODE_W-1:0]          node_next;
   logic [DEPTH-1:0]           leaf_idx;

   // Current node lookup, feature select (out-of-range index falls back to feature 0) and child step
   always_comb begin
      cur_thr  = node_thr_q[node_q];
      cur_fidx = node_fidx_q[node_q];
      feat     = x_q[DATA_W-1:0];
      for (int f = 0; f < N_FEAT; f++) begin
         if (cur_fidx == FIDX_W'(f)) feat = x_q[f*DATA_W +: DATA_W];
      end
      if (CMP_SIGNED != 0) go_left = ($signed(feat) <= $signed(cur_thr));
      else                 go_left = (feat <= cur_thr);
      node_next = go_left ? {node_q, 1'b1} : ({node_q, 1'b0} + NODE_W'(2));
      leaf_idx  = DEPTH'(node_next - NODE_W'(N_NODE));
   end

   // Next-state, result and config-acceptance decode; writes are only honoured while idle
   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      node_d    = node_q;
      lvl_d     = lvl_q;
      y_d       = y_q;
      y_valid_d = 1'b0;
      cfg_err_d = 1'b0;
      node_we   = 1'b0;
      leaf_we   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cfg_we_i) begin
               if (cfg_sel_i)                          leaf_we   = 1'b1;
               else if (cfg_addr_i == DEPTH'(N_NODE))  cfg_err_d = 1'b1;
               else                                    node_we   = 1'b1;
            end
            if (start_i) begin
               state_d = S_EVAL;
               x_d     = x_i;
               node_d  = '0;
               lvl_d   = '0;
            end
         end
         S_EVAL: begin
            cfg_err_d = cfg_we_i;
            lvl_d     = lvl_q + 1'b1;
            node_d    = DEPTH'(node_next);
            if (lvl_q == LVL_W'(DEPTH - 1)) begin
               y_d       = leaf_q[leaf_idx];
               y_valid_d = 1'b1;
               state_d   = S_IDLE;
               node_d    = '0;
               lvl_d     = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control and datapath registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         x_q       <= '0;
         node_q    <= '0;
         lvl_q     <= '0;
         y_q       <= '0;
         y_valid_q <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         node_q    <= node_d;
         lvl_q     <= lvl_d;
         y_q       <= y_d;
         y_valid_q <= y_valid_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   // Node and leaf tables; cleared by reset so an aborted run leaves an empty tree
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_NODE; i++) begin
            node_thr_q[i]  <= '0;
            node_fidx_q[i] <= '0;
         end
         for (int i = 0; i < N_LEAF; i++) leaf_q[i] <= '0;
      end else begin
         if (node_we) begin
            node_thr_q[cfg_addr_i]  <= cfg_data_i[DATA_W-1:0];
            node_fidx_q[cfg_addr_i] <= cfg_data_i[DATA_W +: FIDX_W];
         end
         if (leaf_we) leaf_q[cfg_addr_i] <= cfg_data_i[DATA_W-1:0];
      end
   end

   assign y_o       = y_q;
   assign y_valid_o = y_valid_q;
   assign busy_o    = (state_q == S_EVAL);
   assign cfg_err_o = cfg_err_q;

endmodule
